uart_tx_frame_ctrl: RTL and testbench

//  Sequences one UART transmit frame: start bit, DATA_W data bits (LSB first), optional parity bit, 1 or 2 stop bits.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/uart_tx_frame_ctrl.sv | 114 +++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity encodings, transmit FSM states and the parity helper shared by the UART TX slice.
package uart_pkg;
  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  // Payload is zero-extended by the caller; zero bits do not change the XOR reduction.
  function automatic logic parity_bit(input logic [31:0] data, input logic [1:0] ptype);
    return (ptype == PARITY_ODD) ? ~^data : ^data;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: counts 0..CLKS_PER_BIT-1 while enabled and pulses o_tick on the wrap cycle.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] r_cnt;
  assign o_tick = i_enable && (r_cnt == CW'(CLKS_PER_BIT - 1));
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) r_cnt <= '0;
    else r_cnt <= (i_clear || o_tick || !i_enable) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: one UART TX frame (start, data LSB first, optional parity, 1/2 stop) with Send/Ready/Done.
// Define UART_TX_HOLD_BUF_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int DATA_W   = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_send,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic [1:0]        i_parity_type,
  input  logic              i_stop_bits,
  output logic              o_tx_out,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  tx_state_t         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IW-1:0]     r_bit_idx;
  logic              r_par, r_par_en, r_stop2, r_stop_cnt, r_done;
  logic              w_tick, w_busy, w_accept, w_last, w_start;
  logic [DATA_W-1:0] w_ld_data;
  logic [1:0]        w_ld_ptype;
  logic              w_ld_stop;
  assign w_busy   = r_state != IDLE;
  assign w_accept = i_send && o_ready;
  assign w_last   = (r_state == STOP) && w_tick && (r_stop_cnt == r_stop2);
`ifdef UART_TX_HOLD_BUF_EN
  logic              r_hold_valid, r_hold_stop;
  logic [DATA_W-1:0] r_hold_data;
  logic [1:0]        r_hold_ptype;
  logic              w_load_in, w_load_hold;
  assign o_ready     = !(w_busy && r_hold_valid);
  assign w_load_hold = w_last && r_hold_valid;
  // A Send landing on the completion cycle with an empty holder goes straight onto the line.
  assign w_load_in   = w_accept && (!w_busy || (w_last && !r_hold_valid));
  assign w_start     = w_load_in || w_load_hold;
  assign w_ld_data   = w_load_hold ? r_hold_data : i_data_in;
  assign w_ld_ptype  = w_load_hold ? r_hold_ptype : i_parity_type;
  assign w_ld_stop   = w_load_hold ? r_hold_stop : i_stop_bits;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_hold_ptype <= PARITY_NONE;
      r_hold_stop  <= 1'b0;
    end else if (w_accept && !w_load_in) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= i_data_in;
      r_hold_ptype <= i_parity_type;
      r_hold_stop  <= i_stop_bits;
    end else if (w_load_hold) r_hold_valid <= 1'b0;
`else
  assign o_ready    = !w_busy;
  assign w_start    = w_accept;
  assign w_ld_data  = i_data_in;
  assign w_ld_ptype = i_parity_type;
  assign w_ld_stop  = i_stop_bits;
`endif
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (w_start),
    .i_enable(w_busy),
    .o_tick  (w_tick)
  );
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_par      <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_start) begin
        r_state    <= START;
        r_shift    <= w_ld_data;
        r_bit_idx  <= '0;
        r_par      <= parity_bit(32'(w_ld_data), w_ld_ptype);
        r_par_en   <= (w_ld_ptype == PARITY_ODD) || (w_ld_ptype == PARITY_EVEN);
        r_stop2    <= w_ld_stop;
        r_stop_cnt <= 1'b0;
      end else if (w_tick)
        case (r_state)
          START:  r_state <= DATA;
          DATA: begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == IW'(DATA_W - 1)) r_state <= r_par_en ? PARITY : STOP;
          end
          PARITY: r_state <= STOP;
          STOP: begin
            if (r_stop_cnt == r_stop2) r_state <= IDLE;
            r_stop_cnt <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
    end
  assign o_tx_out = (r_state == START) ? 1'b0 :
                    (r_state == DATA) ? r_shift[0] :
                    (r_state == PARITY) ? r_par : 1'b1;
  assign o_busy = w_busy;
  assign o_done = r_done;
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb_uart_tx_frame_ctrl: directed scenarios at 16 clocks per bit, 8 data bits.
module tb_uart_tx_frame_ctrl;
  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_send = 1'b0;
  logic [7:0] i_data_in = 8'h00;
  logic [1:0] i_parity_type = 2'b00;
  logic       i_stop_bits = 1'b0;
  logic       o_tx_out, o_ready, o_busy, o_done;
  int n_chk = 0;
  int n_pass = 0;
  uart_tx_frame_ctrl #(.CLK_FREQ(16), .BAUD(1), .DATA_W(8)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_send(i_send), .i_data_in(i_data_in),
    .i_parity_type(i_parity_type), .i_stop_bits(i_stop_bits),
    .o_tx_out(o_tx_out), .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Sends one frame and records mid-bit line samples, Done timing and Busy length (no checking here).
  task automatic send_frame(input logic [7:0] d, input logic [1:0] p, input logic s, input logic disturb,
                            output logic [10:0] bits, output int done_at, output int busy_cnt, output int done_cnt);
    i_data_in = d; i_parity_type = p; i_stop_bits = s; i_send = 1'b1;
    step();
    i_send = 1'b0;
    bits = '0; done_at = -1; done_cnt = 0; busy_cnt = o_busy ? 1 : 0;
    for (int c = 1; c <= 220; c++) begin
      if (disturb && c == 20) begin i_send = 1'b1; i_data_in = ~d; i_parity_type = 2'b01; i_stop_bits = ~s; end
      if (disturb && c == 21) i_send = 1'b0;
      step();
      if (c >= 8 && (c - 8) % 16 == 0 && (c - 8) / 16 < 11) bits[(c - 8) / 16] = o_tx_out;
      if (done_at < 0 && o_busy) busy_cnt++;
      if (o_done) begin done_cnt++; if (done_at < 0) done_at = c; end
    end
  endtask
  task automatic test_reset();
    logic [10:0] bits; int da, bc, dc;
    #1;
    n_chk++; if (o_tx_out !== 1'b1) $display("FAIL rst_tx got %b exp 1", o_tx_out); else n_pass++;
    n_chk++; if (o_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", o_ready); else n_pass++;
    n_chk++; if (o_busy !== 1'b0 || o_done !== 1'b0) $display("FAIL rst_busy_done got %b%b exp 00", o_busy, o_done); else n_pass++;
    step(); step();
    i_reset = 1'b0;
    step();
    i_data_in = 8'h55; i_parity_type = 2'b00; i_stop_bits = 1'b0; i_send = 1'b1;
    step();
    i_send = 1'b0;
    for (int c = 1; c <= 40; c++) step();
    n_chk++; if (o_tx_out !== 1'b0 || o_busy !== 1'b1) $display("FAIL mid_data got tx=%b busy=%b exp tx=0 busy=1", o_tx_out, o_busy); else n_pass++;
    #2 i_reset = 1'b1;
    #1;
    n_chk++; if (o_tx_out !== 1'b1) $display("FAIL async_rst_tx got %b exp 1", o_tx_out); else n_pass++;
    n_chk++; if (o_busy !== 1'b0 || o_ready !== 1'b1) $display("FAIL async_rst_flags got busy=%b ready=%b exp 0/1", o_busy, o_ready); else n_pass++;
    step();
    i_reset = 1'b0;
    step();
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, bits, da, bc, dc);
    n_chk++; if (bits !== {1'b1, 1'b1, 8'h55, 1'b0}) $display("FAIL post_rst_bits got %b exp %b", bits, {1'b1, 1'b1, 8'h55, 1'b0}); else n_pass++;
    n_chk++; if (da !== 160 || dc !== 1) $display("FAIL post_rst_done got at=%0d n=%0d exp at=160 n=1", da, dc); else n_pass++;
  endtask
  task automatic test_odd_parity();
    logic [10:0] bits; int da, bc, dc;
    send_frame(8'hA5, 2'b01, 1'b0, 1'b0, bits, da, bc, dc);
    n_chk++; if (bits !== {1'b1, 1'b1, 8'hA5, 1'b0}) $display("FAIL odd_bits got %b exp %b", bits, {1'b1, 1'b1, 8'hA5, 1'b0}); else n_pass++;
    n_chk++; if (da !== 176) $display("FAIL odd_done_at got %0d exp 176", da); else n_pass++;
    n_chk++; if (dc !== 1) $display("FAIL odd_done_pulses got %0d exp 1", dc); else n_pass++;
  endtask
  task automatic test_even_parity();
    logic [10:0] bits; int da, bc, dc;
    send_frame(8'h07, 2'b10, 1'b0, 1'b0, bits, da, bc, dc);
    n_chk++; if (bits[9] !== 1'b1) $display("FAIL even_par got %b exp 1", bits[9]); else n_pass++;
    n_chk++; if (bits !== {1'b1, 1'b1, 8'h07, 1'b0}) $display("FAIL even_bits got %b exp %b", bits, {1'b1, 1'b1, 8'h07, 1'b0}); else n_pass++;
    n_chk++; if (bc !== 176) $display("FAIL even_busy_len got %0d exp 176", bc); else n_pass++;
    n_chk++; if (da !== 176) $display("FAIL even_done_at got %0d exp 176", da); else n_pass++;
  endtask
  task automatic test_two_stop();
    logic [10:0] bits; int da, bc, dc;
    send_frame(8'h00, 2'b11, 1'b1, 1'b0, bits, da, bc, dc);
    n_chk++; if (bits !== {1'b1, 1'b1, 8'h00, 1'b0}) $display("FAIL stop2_bits got %b exp %b", bits, {1'b1, 1'b1, 8'h00, 1'b0}); else n_pass++;
    n_chk++; if (da !== 176) $display("FAIL stop2_done_at got %0d exp 176", da); else n_pass++;
    n_chk++; if (bc !== 176) $display("FAIL stop2_busy_len got %0d exp 176", bc); else n_pass++;
  endtask
`ifdef UART_TX_HOLD_BUF_EN
  task automatic test_hold_buffer();
    logic [9:0] bits2; int d1, d2, dc;
    bits2 = '0; d1 = -1; d2 = -1; dc = 0;
    i_data_in = 8'h12; i_parity_type = 2'b00; i_stop_bits = 1'b0; i_send = 1'b1;
    step();
    i_send = 1'b0;
    for (int c = 1; c <= 340; c++) begin
      if (c == 5) begin i_send = 1'b1; i_data_in = 8'h34; end
      step();
      if (c == 3) begin n_chk++; if (o_ready !== 1'b1) $display("FAIL hold_ready_empty got %b exp 1", o_ready); else n_pass++; end
      if (c == 5) begin
        i_send = 1'b0; i_data_in = 8'hFF;
        n_chk++; if (o_ready !== 1'b0) $display("FAIL hold_ready_full got %b exp 0", o_ready); else n_pass++;
      end
      if (c == 159) begin n_chk++; if (o_tx_out !== 1'b1) $display("FAIL hold_stop got %b exp 1", o_tx_out); else n_pass++; end
      if (c == 160) begin
        n_chk++; if (o_done !== 1'b1 || o_tx_out !== 1'b0 || o_busy !== 1'b1)
          $display("FAIL hold_b2b got done=%b tx=%b busy=%b exp 1/0/1", o_done, o_tx_out, o_busy); else n_pass++;
        n_chk++; if (o_ready !== 1'b1) $display("FAIL hold_ready_drained got %b exp 1", o_ready); else n_pass++;
      end
      if (c >= 168 && (c - 168) % 16 == 0 && (c - 168) / 16 < 10) bits2[(c - 168) / 16] = o_tx_out;
      if (o_done) begin dc++; if (d1 < 0) d1 = c; else d2 = c; end
    end
    n_chk++; if (dc !== 2 || d1 !== 160 || d2 !== 320) $display("FAIL hold_done got n=%0d at %0d,%0d exp n=2 at 160,320", dc, d1, d2); else n_pass++;
    n_chk++; if (bits2 !== {1'b1, 8'h34, 1'b0}) $display("FAIL hold_frame2 got %b exp %b", bits2, {1'b1, 8'h34, 1'b0}); else n_pass++;
  endtask
`else
  task automatic test_ignore_busy();
    logic [10:0] bits; int da, bc, dc;
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1, bits, da, bc, dc);
    n_chk++; if (bits !== {1'b1, 1'b1, 8'h3C, 1'b0}) $display("FAIL ignore_bits got %b exp %b", bits, {1'b1, 1'b1, 8'h3C, 1'b0}); else n_pass++;
    n_chk++; if (da !== 160 || dc !== 1) $display("FAIL ignore_done got at=%0d n=%0d exp at=160 n=1", da, dc); else n_pass++;
  endtask
  task automatic test_back_to_back();
    int d2;
    d2 = -1;
    i_data_in = 8'h81; i_parity_type = 2'b00; i_stop_bits = 1'b0; i_send = 1'b1;
    step();
    for (int c = 1; c <= 330; c++) begin
      step();
      if (c == 160) begin
        n_chk++; if (o_done !== 1'b1 || o_ready !== 1'b1 || o_tx_out !== 1'b1)
          $display("FAIL b2b_gap got done=%b ready=%b tx=%b exp 1/1/1", o_done, o_ready, o_tx_out); else n_pass++;
      end
      if (c == 161) begin
        i_send = 1'b0;
        n_chk++; if (o_tx_out !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b0)
          $display("FAIL b2b_restart got tx=%b busy=%b done=%b exp 0/1/0", o_tx_out, o_busy, o_done); else n_pass++;
      end
      if (c > 161 && o_done && d2 < 0) d2 = c;
    end
    n_chk++; if (d2 !== 321) $display("FAIL b2b_done2 got %0d exp 321", d2); else n_pass++;
  endtask
`endif
  initial begin
    test_reset();
    test_odd_parity();
    test_even_parity();
    test_two_stop();
`ifdef UART_TX_HOLD_BUF_EN
    test_hold_buffer();
`else
    test_ignore_busy();
    test_back_to_back();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
